// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded ID operands and control, the WB write port
// seen by the bypass, pipeline control, and the registered EX-side outputs.
interface id_ex_stage_if #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
);
  // ID side
  logic              id_valid;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [31:0]       id_rdata1;
  logic [31:0]       id_rdata2;
  logic [31:0]       id_imm;
  logic [4:0]        id_wreg;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_memwrite;
  logic [CTRL_W-1:0] id_ctrl;
  // WB write port, same signals that drive the regfile
  logic              wb_we;
  logic [4:0]        wb_reg;
  logic [31:0]       wb_data;
  // pipeline control
  logic              flush;
  logic              ex_hold;
  logic              stall_out;
  // EX side
  logic              ex_valid;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_wreg;
  logic [31:0]       ex_a;
  logic [31:0]       ex_b;
  logic [31:0]       ex_imm;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_memwrite;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  perf_bubbles;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rdata1, id_rdata2,
           id_imm, id_wreg, id_regwrite, id_memread, id_memwrite, id_ctrl,
           wb_we, wb_reg, wb_data, flush, ex_hold,
    input  stall_out, ex_valid, ex_rs, ex_rt, ex_wreg, ex_a, ex_b, ex_imm,
           ex_regwrite, ex_memread, ex_memwrite, ex_ctrl, perf_bubbles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rdata1, id_rdata2,
           id_imm, id_wreg, id_regwrite, id_memread, id_memwrite, id_ctrl,
           wb_we, wb_reg, wb_data, flush, ex_hold,
    output stall_out, ex_valid, ex_rs, ex_rt, ex_wreg, ex_a, ex_b, ex_imm,
           ex_regwrite, ex_memread, ex_memwrite, ex_ctrl, perf_bubbles
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Bypasses a same-cycle WB write into the captured
// operands, detects load-use hazards, inserts bubbles on hazard or flush,
// freezes on ex_hold, and counts hazard bubbles in a saturating counter.
module id_ex_stage #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  // The regfile writes on the same edge ID samples, so a matching WB write
  // must be forwarded here. R0 is hardwired to zero and wins over WB.
  function automatic logic [31:0] bypass(
    input logic [4:0]  src,
    input logic [31:0] rdata,
    input logic        we,
    input logic [4:0]  wreg,
    input logic [31:0] wdata
  );
    if (src == 5'd0)
      return 32'd0;
    else if (we && (wreg == src))
      return wdata;
    else
      return rdata;
  endfunction

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c)
      return c;
    else
      return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // ---------------- stage p1 registers (EX side) ----------------
  logic              vld_p1;
  logic [4:0]        rs_p1;
  logic [4:0]        rt_p1;
  logic [4:0]        wreg_p1;
  logic [31:0]       a_p1;
  logic [31:0]       b_p1;
  logic [31:0]       imm_p1;
  logic              regwrite_p1;
  logic              memread_p1;
  logic              memwrite_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic [CNT_W-1:0]  bubbles_q;

  // ---------------- stage p0 (ID side, combinational) ----------------
  logic        luh_p0;
  logic [31:0] opa_p0;
  logic [31:0] opb_p0;
  logic        bubble_p0;
  logic        load_p0;

  // Hazard detection, operand bypass and update selection for this cycle.
  always_comb begin
    luh_p0    = 1'b0;
    opa_p0    = 32'd0;
    opb_p0    = 32'd0;
    bubble_p0 = 1'b0;
    load_p0   = 1'b0;

    luh_p0 = vld_p1 && memread_p1 && (wreg_p1 != 5'd0) && bus.id_valid &&
             ((bus.id_use_rs && (bus.id_rs == wreg_p1)) ||
              (bus.id_use_rt && (bus.id_rt == wreg_p1)));

    opa_p0 = bypass(bus.id_rs, bus.id_rdata1, bus.wb_we, bus.wb_reg, bus.wb_data);
    opb_p0 = bypass(bus.id_rt, bus.id_rdata2, bus.wb_we, bus.wb_reg, bus.wb_data);

    // flush beats hold, hold beats the hazard bubble, otherwise load.
    bubble_p0 = bus.flush || (!bus.ex_hold && luh_p0);
    load_p0   = !bus.flush && !bus.ex_hold && !luh_p0;
  end

  // Valid and control bits: cleared on a bubble, frozen on hold,
  // otherwise loaded and gated by id_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      regwrite_p1 <= 1'b0;
      memread_p1  <= 1'b0;
      memwrite_p1 <= 1'b0;
      ctrl_p1     <= '0;
    end else if (bubble_p0) begin
      vld_p1      <= 1'b0;
      regwrite_p1 <= 1'b0;
      memread_p1  <= 1'b0;
      memwrite_p1 <= 1'b0;
      ctrl_p1     <= '0;
    end else if (load_p0) begin
      vld_p1      <= bus.id_valid;
      regwrite_p1 <= bus.id_valid & bus.id_regwrite;
      memread_p1  <= bus.id_valid & bus.id_memread;
      memwrite_p1 <= bus.id_valid & bus.id_memwrite;
      ctrl_p1     <= bus.id_valid ? bus.id_ctrl : '0;
    end
  end

  // Operand and register-number fields: only loaded on a real load slot;
  // on bubbles and holds they keep whatever they held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_p1   <= 5'd0;
      rt_p1   <= 5'd0;
      wreg_p1 <= 5'd0;
      a_p1    <= 32'd0;
      b_p1    <= 32'd0;
      imm_p1  <= 32'd0;
    end else if (load_p0) begin
      rs_p1   <= bus.id_rs;
      rt_p1   <= bus.id_rt;
      wreg_p1 <= bus.id_wreg;
      a_p1    <= opa_p0;
      b_p1    <= opb_p0;
      imm_p1  <= bus.id_imm;
    end
  end

  // Bubble counter: counts only hazard bubbles that actually get inserted
  // (a flush or hold in the same cycle suppresses the hazard bubble).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bubbles_q <= '0;
    else if (!bus.flush && !bus.ex_hold && luh_p0)
      bubbles_q <= sat_inc(bubbles_q);
  end

  assign bus.stall_out    = (luh_p0 | bus.ex_hold) & ~bus.flush;
  assign bus.ex_valid     = vld_p1;
  assign bus.ex_rs        = rs_p1;
  assign bus.ex_rt        = rt_p1;
  assign bus.ex_wreg      = wreg_p1;
  assign bus.ex_a         = a_p1;
  assign bus.ex_b         = b_p1;
  assign bus.ex_imm       = imm_p1;
  assign bus.ex_regwrite  = regwrite_p1;
  assign bus.ex_memread   = memread_p1;
  assign bus.ex_memwrite  = memwrite_p1;
  assign bus.ex_ctrl      = ctrl_p1;
  assign bus.perf_bubbles = bubbles_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: table of directed vectors plus hand-written
// sequences for hold, counter saturation and asynchronous reset.
module tb_id_ex_stage;

  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst;

  id_ex_stage_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total;
  int n_pass;

  typedef struct {
    logic        v;
    logic [4:0]  rs, rt;
    logic        urs, urt;
    logic [31:0] rd1, rd2;
    logic [4:0]  wreg;
    logic        rw, mr, mw;
    logic [7:0]  ctrl;
    logic        wbwe;
    logic [4:0]  wbreg;
    logic [31:0] wbdata;
    logic        fl, hold;
    logic        e_stall, e_valid;
    logic [31:0] e_a, e_b;
    logic [4:0]  e_wreg;
    logic        e_rw, e_mr, e_mw;
    logic [7:0]  e_ctrl;
    logic [3:0]  e_perf;
    logic        chk_data;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk_in(logic v, logic [4:0] rs, logic [4:0] rt,
                                 logic urs, logic urt, logic [31:0] rd1,
                                 logic [31:0] rd2, logic [4:0] wreg,
                                 logic rw, logic mr, logic mw, logic [7:0] ctrl,
                                 logic wbwe, logic [4:0] wbreg,
                                 logic [31:0] wbdata, logic fl, logic hold);
    vec_t t;
    t = '{default: '0};
    t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt;
    t.rd1 = rd1; t.rd2 = rd2; t.wreg = wreg;
    t.rw = rw; t.mr = mr; t.mw = mw; t.ctrl = ctrl;
    t.wbwe = wbwe; t.wbreg = wbreg; t.wbdata = wbdata;
    t.fl = fl; t.hold = hold;
    return t;
  endfunction

  function automatic vec_t mk_exp(vec_t t, logic stall, logic valid,
                                  logic [31:0] a, logic [31:0] b,
                                  logic [4:0] wreg, logic rw, logic mr,
                                  logic mw, logic [7:0] ctrl,
                                  logic [3:0] perf, logic chk);
    vec_t r;
    r = t;
    r.e_stall = stall; r.e_valid = valid; r.e_a = a; r.e_b = b;
    r.e_wreg = wreg; r.e_rw = rw; r.e_mr = mr; r.e_mw = mw;
    r.e_ctrl = ctrl; r.e_perf = perf; r.chk_data = chk;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic drive(input vec_t t);
    bus.id_valid    = t.v;
    bus.id_rs       = t.rs;
    bus.id_rt       = t.rt;
    bus.id_use_rs   = t.urs;
    bus.id_use_rt   = t.urt;
    bus.id_rdata1   = t.rd1;
    bus.id_rdata2   = t.rd2;
    bus.id_imm      = t.rd1 ^ 32'h5555_0000;
    bus.id_wreg     = t.wreg;
    bus.id_regwrite = t.rw;
    bus.id_memread  = t.mr;
    bus.id_memwrite = t.mw;
    bus.id_ctrl     = t.ctrl;
    bus.wb_we       = t.wbwe;
    bus.wb_reg      = t.wbreg;
    bus.wb_data     = t.wbdata;
    bus.flush       = t.fl;
    bus.ex_hold     = t.hold;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // lw $8, 0($29): a load whose destination is $8
  function automatic vec_t lw8();
    return mk_in(1, 29, 8, 1, 0, 32'h1000, 32'h0, 8, 1, 1, 0, 8'h11,
                 0, 0, 32'h0, 0, 0);
  endfunction

  // add $10, $8, $9: reads $8 as rs
  function automatic vec_t use8();
    return mk_in(1, 8, 9, 1, 1, 32'h80, 32'h90, 10, 1, 0, 0, 8'h22,
                 0, 0, 32'h0, 0, 0);
  endfunction

  initial begin
    vec_t t;
    logic [3:0] exp_perf;
    n_total = 0;
    n_pass  = 0;

    // vectors: inputs, then expected EX state after the edge
    tbl[0]  = mk_exp(mk_in(1, 5, 6, 1, 1, 32'h11, 32'h22, 7, 1, 0, 0, 8'h5A,
                           1, 5, 32'hABCD, 0, 0),
                     0, 1, 32'hABCD, 32'h22, 7, 1, 0, 0, 8'h5A, 0, 1);
    tbl[1]  = mk_exp(mk_in(1, 0, 6, 1, 1, 32'h11, 32'h22, 7, 1, 0, 0, 8'h5A,
                           1, 0, 32'hABCD, 0, 0),
                     0, 1, 32'h0, 32'h22, 7, 1, 0, 0, 8'h5A, 0, 1);
    tbl[2]  = mk_exp(mk_in(1, 3, 9, 1, 1, 32'h33, 32'h99, 4, 1, 0, 0, 8'h01,
                           1, 9, 32'h1234, 0, 0),
                     0, 1, 32'h33, 32'h1234, 4, 1, 0, 0, 8'h01, 0, 1);
    tbl[3]  = mk_exp(mk_in(1, 9, 0, 1, 1, 32'h99, 32'h55, 0, 0, 0, 1, 8'h0C,
                           0, 9, 32'hDEAD, 0, 0),
                     0, 1, 32'h99, 32'h0, 0, 0, 0, 1, 8'h0C, 0, 1);
    tbl[4]  = mk_exp(lw8(), 0, 1, 32'h1000, 32'h0, 8, 1, 1, 0, 8'h11, 0, 1);
    tbl[5]  = mk_exp(use8(), 1, 0, 32'h0, 32'h0, 0, 0, 0, 0, 8'h00, 1, 0);
    tbl[6]  = mk_exp(use8(), 0, 1, 32'h80, 32'h90, 10, 1, 0, 0, 8'h22, 1, 1);
    tbl[7]  = mk_exp(mk_in(1, 29, 8, 1, 0, 32'h2000, 32'h77, 8, 1, 1, 0, 8'h11,
                           0, 0, 32'h0, 0, 0),
                     0, 1, 32'h2000, 32'h77, 8, 1, 1, 0, 8'h11, 1, 1);
    tbl[8]  = mk_exp(mk_in(1, 3, 8, 1, 0, 32'h33, 32'h88, 12, 1, 0, 0, 8'h33,
                           0, 0, 32'h0, 0, 0),
                     0, 1, 32'h33, 32'h88, 12, 1, 0, 0, 8'h33, 1, 1);
    tbl[9]  = mk_exp(mk_in(1, 29, 0, 1, 0, 32'h3000, 32'h0, 0, 1, 1, 0, 8'h44,
                           0, 0, 32'h0, 0, 0),
                     0, 1, 32'h3000, 32'h0, 0, 1, 1, 0, 8'h44, 1, 1);
    tbl[10] = mk_exp(mk_in(1, 0, 0, 1, 1, 32'h0, 32'h0, 13, 1, 0, 0, 8'h55,
                           0, 0, 32'h0, 0, 0),
                     0, 1, 32'h0, 32'h0, 13, 1, 0, 0, 8'h55, 1, 1);
    tbl[11] = mk_exp(mk_in(1, 29, 8, 1, 0, 32'h4000, 32'h0, 8, 1, 1, 0, 8'h11,
                           0, 0, 32'h0, 0, 0),
                     0, 1, 32'h4000, 32'h0, 8, 1, 1, 0, 8'h11, 1, 1);
    t = use8(); t.fl = 1;
    tbl[12] = mk_exp(t, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 8'h00, 1, 0);
    tbl[13] = mk_exp(mk_in(1, 29, 8, 1, 0, 32'h5000, 32'h0, 8, 1, 1, 0, 8'h11,
                           0, 0, 32'h0, 0, 0),
                     0, 1, 32'h5000, 32'h0, 8, 1, 1, 0, 8'h11, 1, 1);
    tbl[14] = mk_exp(mk_in(1, 1, 2, 1, 1, 32'h1, 32'h2, 3, 1, 0, 0, 8'h66,
                           0, 0, 32'h0, 1, 1),
                     0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 8'h00, 1, 0);
    tbl[15] = mk_exp(mk_in(0, 2, 3, 1, 1, 32'h2, 32'h3, 5, 1, 1, 1, 8'hFF,
                           0, 0, 32'h0, 0, 0),
                     0, 0, 32'h2, 32'h3, 5, 0, 0, 0, 8'h00, 1, 1);

    // asynchronous reset at time zero, before any clock edge
    t = '{default: '0};
    drive(t);
    rst = 1'b1;
    #2;
    chk("rst0_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst0_a", bus.ex_a, 32'd0);
    chk("rst0_ctrl", {24'd0, bus.ex_ctrl}, 32'd0);
    chk("rst0_perf", {28'd0, bus.perf_bubbles}, 32'd0);
    step();
    step();
    rst = 1'b0;

    // table-driven vectors
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, bus.stall_out}, {31'd0, tbl[i].e_stall});
      step();
      chk($sformatf("v%0d_valid", i), {31'd0, bus.ex_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("v%0d_rw", i), {31'd0, bus.ex_regwrite}, {31'd0, tbl[i].e_rw});
      chk($sformatf("v%0d_mr", i), {31'd0, bus.ex_memread}, {31'd0, tbl[i].e_mr});
      chk($sformatf("v%0d_mw", i), {31'd0, bus.ex_memwrite}, {31'd0, tbl[i].e_mw});
      chk($sformatf("v%0d_ctrl", i), {24'd0, bus.ex_ctrl}, {24'd0, tbl[i].e_ctrl});
      chk($sformatf("v%0d_perf", i), {28'd0, bus.perf_bubbles}, {28'd0, tbl[i].e_perf});
      if (tbl[i].chk_data) begin
        chk($sformatf("v%0d_a", i), bus.ex_a, tbl[i].e_a);
        chk($sformatf("v%0d_b", i), bus.ex_b, tbl[i].e_b);
        chk($sformatf("v%0d_wreg", i), {27'd0, bus.ex_wreg}, {27'd0, tbl[i].e_wreg});
        chk($sformatf("v%0d_rs", i), {27'd0, bus.ex_rs}, {27'd0, tbl[i].rs});
        chk($sformatf("v%0d_rt", i), {27'd0, bus.ex_rt}, {27'd0, tbl[i].rt});
        chk($sformatf("v%0d_imm", i), bus.ex_imm, tbl[i].rd1 ^ 32'h5555_0000);
      end
    end

    // hold for 3 cycles with a load in EX and a dependent instruction in ID
    t = mk_in(1, 1, 2, 1, 1, 32'h111, 32'h222, 3, 1, 1, 0, 8'h66,
              0, 0, 32'h0, 0, 0);
    drive(t);
    step();
    t = mk_in(1, 3, 4, 1, 1, 32'h999, 32'h444, 9, 1, 0, 1, 8'h77,
              0, 0, 32'h0, 0, 1);
    drive(t);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold%0d_stall", k), {31'd0, bus.stall_out}, 32'd1);
      step();
      chk($sformatf("hold%0d_valid", k), {31'd0, bus.ex_valid}, 32'd1);
      chk($sformatf("hold%0d_a", k), bus.ex_a, 32'h111);
      chk($sformatf("hold%0d_b", k), bus.ex_b, 32'h222);
      chk($sformatf("hold%0d_wreg", k), {27'd0, bus.ex_wreg}, 32'd3);
      chk($sformatf("hold%0d_ctrl", k), {24'd0, bus.ex_ctrl}, 32'h66);
      chk($sformatf("hold%0d_mw", k), {31'd0, bus.ex_memwrite}, 32'd0);
      chk($sformatf("hold%0d_imm", k), bus.ex_imm, 32'h111 ^ 32'h5555_0000);
      chk($sformatf("hold%0d_perf", k), {28'd0, bus.perf_bubbles}, 32'd1);
    end
    // hold released: the pending load-use now inserts its bubble
    t.hold = 1'b0;
    drive(t);
    #1;
    chk("unhold_stall", {31'd0, bus.stall_out}, 32'd1);
    step();
    chk("unhold_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("unhold_perf", {28'd0, bus.perf_bubbles}, 32'd2);
    #1;
    chk("unhold_stall_drop", {31'd0, bus.stall_out}, 32'd0);
    step();
    chk("unhold_load_a", bus.ex_a, 32'h999);
    chk("unhold_load_mw", {31'd0, bus.ex_memwrite}, 32'd1);

    // drive the bubble counter into saturation, then one more hazard
    exp_perf = 4'd2;
    for (int k = 0; k < 15; k++) begin
      drive(lw8());
      step();
      drive(use8());
      #1;
      chk($sformatf("sat%0d_stall", k), {31'd0, bus.stall_out}, 32'd1);
      step();
      exp_perf = (exp_perf == 4'hF) ? 4'hF : exp_perf + 4'd1;
      chk($sformatf("sat%0d_perf", k), {28'd0, bus.perf_bubbles}, {28'd0, exp_perf});
    end
    chk("sat_final", {28'd0, bus.perf_bubbles}, 32'hF);

    // mid-cycle asynchronous reset with a valid instruction in EX
    drive(mk_in(1, 1, 2, 1, 1, 32'hAA, 32'hBB, 6, 1, 1, 1, 8'hC3,
                0, 0, 32'h0, 0, 0));
    step();
    chk("pre_rst_valid", {31'd0, bus.ex_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_a", bus.ex_a, 32'd0);
    chk("rst_b", bus.ex_b, 32'd0);
    chk("rst_imm", bus.ex_imm, 32'd0);
    chk("rst_wreg", {27'd0, bus.ex_wreg}, 32'd0);
    chk("rst_rs", {27'd0, bus.ex_rs}, 32'd0);
    chk("rst_rt", {27'd0, bus.ex_rt}, 32'd0);
    chk("rst_ctl", {29'd0, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite}, 32'd0);
    chk("rst_ctrl", {24'd0, bus.ex_ctrl}, 32'd0);
    chk("rst_perf", {28'd0, bus.perf_bubbles}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_rel_valid", {31'd0, bus.ex_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
